// File: rtl/header_assembler.sv
// header_assembler: frames the host UART byte stream into an 80-byte block header, published atomically.
// Optional idle timer that discards stale partial frames is enabled by defining HDR_TIMEOUT_EN.
module header_assembler #(
    parameter int HEADER_BYTES   = 80,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    input  logic                      flush,
    output logic [8*HEADER_BYTES-1:0] block_header,
    output logic                      header_valid,
    output logic                      header_loaded,
    output logic                      busy,
    output logic [31:0]               byte_count,
    output logic                      timeout
);
    localparam int W     = 8 * HEADER_BYTES;
    localparam int IDX_W = (HEADER_BYTES > 1) ? $clog2(HEADER_BYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(HEADER_BYTES - 1);

    if (HEADER_BYTES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("header_assembler: HEADER_BYTES must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    // The oldest byte always falls off on the next shift, so only the newest W-8 bits are kept.
    logic [W-9:0]     shreg;
    logic [W-1:0]     shifted;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_next;
    logic             accept;
    logic             frame_done;
    logic             expire;

    assign accept     = rx_valid && !flush;
    assign shifted    = {shreg, rx_data};
    assign frame_done = accept && (idx == IDX_LAST);

`ifdef HDR_TIMEOUT_EN
    localparam logic [31:0] IDLE_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] idle;
    logic [31:0] idle_next;

    // An arriving byte or a flush takes precedence over an expiring timer.
    assign expire = !flush && !rx_valid && (idx != '0) && (idle == IDLE_LAST);

    always_comb begin
        idle_next = idle;
        if (flush || rx_valid || expire || (idx == '0)) begin
            idle_next = '0;
        end else begin
            idle_next = idle + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idle <= '0;
        end else begin
            idle <= idle_next;
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        idx_next = idx;
        if (flush || expire || frame_done) begin
            idx_next = '0;
        end else if (accept) begin
            idx_next = idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shreg         <= '0;
            idx           <= '0;
            block_header  <= '0;
            header_valid  <= 1'b0;
            header_loaded <= 1'b0;
            busy          <= 1'b0;
            byte_count    <= '0;
            timeout       <= 1'b0;
        end else begin
            if (accept) begin
                shreg      <= shifted[W-9:0];
                byte_count <= byte_count + 32'd1;
            end
            if (frame_done) begin
                block_header  <= shifted;
                header_loaded <= 1'b1;
            end
            idx          <= idx_next;
            header_valid <= frame_done;
            busy         <= (idx_next != '0);
            timeout      <= expire;
        end
    end
endmodule

// File: tb/tb_header_assembler.sv
// tb_header_assembler: directed table, hand-written corner sequences and random traffic
// checked every cycle against a queue-based frame model.
module tb_header_assembler;
    localparam int HB = 80;
    localparam int W  = 8 * HB;
    localparam int TO = 16;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [7:0]   rx_data = '0;
    logic         rx_valid = 1'b0;
    logic         flush = 1'b0;
    logic [W-1:0] block_header;
    logic         header_valid;
    logic         header_loaded;
    logic         busy;
    logic [31:0]  byte_count;
    logic         timeout;

    header_assembler #(.HEADER_BYTES(HB), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .flush(flush),
        .block_header(block_header), .header_valid(header_valid), .header_loaded(header_loaded),
        .busy(busy), .byte_count(byte_count), .timeout(timeout)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: the current frame is a queue of bytes; a header is the queue packed MSB-first.
    logic [7:0]   frame_q[$];
    logic [W-1:0] m_header = '0;
    logic         m_hv = 1'b0, m_loaded = 1'b0, m_busy = 1'b0, m_to = 1'b0;
    logic [31:0]  m_count = '0;
    int           m_gap = 0;
    int           n_hv = 0, n_to = 0, cyc = 0;
    int           hv_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_w(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic f, input logic r);
        m_hv = 1'b0;
        m_to = 1'b0;
        if (r) begin
            frame_q.delete();
            m_gap = 0; m_count = '0; m_header = '0; m_loaded = 1'b0;
        end else if (f) begin
            frame_q.delete();
            m_gap = 0;
        end else if (v) begin
            m_count++;
            m_gap = 0;
            frame_q.push_back(d);
            if (frame_q.size() == HB) begin
                for (int i = 0; i < HB; i++) m_header[W-1-8*i -: 8] = frame_q[i];
                m_hv = 1'b1;
                m_loaded = 1'b1;
                frame_q.delete();
            end
        end else if (frame_q.size() != 0) begin
`ifdef HDR_TIMEOUT_EN
            if (m_gap == TO - 1) begin
                frame_q.delete();
                m_gap = 0;
                m_to = 1'b1;
            end else begin
                m_gap++;
            end
`endif
        end
        m_busy = (frame_q.size() != 0);
    endtask

    task automatic cycle(input logic v, input logic [7:0] d, input logic f, input logic r);
        rx_valid = v; rx_data = d; flush = f; reset = r;
        @(posedge clock);
        model_step(v, d, f, r);
        @(negedge clock);
        cyc++;
        chk_w("block_header", block_header, m_header);
        chk("header_valid", header_valid, m_hv);
        chk("header_loaded", header_loaded, m_loaded);
        chk("busy", busy, m_busy);
        chk("byte_count", byte_count, m_count);
        chk("timeout", timeout, m_to);
        if (header_valid === 1'b1) begin n_hv++; hv_cyc.push_back(cyc); end
        if (timeout === 1'b1) n_to++;
    endtask

    task automatic send(input logic [7:0] d);
        cycle(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        f;
        logic        r;
        logic [31:0] cnt;
        logic        bsy;
        logic        ld;
    } vec_t;

    vec_t         tbl[8];
    logic [W-1:0] e1, e2;
    logic [7:0]   rb[HB];
    int           hv0, to0;

    initial begin
        tbl[0] = '{1'b0, 8'h00, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 8'h5A, 1'b0, 1'b0, 32'd1, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 32'd1, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 8'h33, 1'b1, 1'b0, 32'd1, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 8'h01, 1'b0, 1'b0, 32'd2, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 8'h02, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 8'h03, 1'b0, 1'b0, 32'd1, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 32'd1, 1'b0, 1'b0};

        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].r);
            chk("tbl_count", byte_count, tbl[i].cnt);
            chk("tbl_busy", busy, tbl[i].bsy);
            chk("tbl_loaded", header_loaded, tbl[i].ld);
        end

        for (int i = 0; i < HB; i++) e1[W-1-8*i -: 8] = 8'(i);

        // Contiguous frame 0x00..0x4F
        do_reset();
        chk_w("reset_header", block_header, '0);
        hv0 = n_hv;
        for (int i = 0; i < HB; i++) send(8'(i));
        chk("t1_first_byte", block_header[639:632], 32'h00);
        chk("t1_last_byte", block_header[7:0], 32'h4F);
        chk_w("t1_header", block_header, e1);
        chk("t1_hv_now", header_valid, 1);
        chk("t1_hv_count", n_hv - hv0, 1);
        chk("t1_count", byte_count, 80);
        chk("t1_busy", busy, 0);
        chk("t1_loaded", header_loaded, 1);
        idle_n(1);
        chk("t1_hv_one_cycle", header_valid, 0);

        // Same frame with random gaps
        do_reset();
        hv0 = n_hv;
        for (int i = 0; i < HB; i++) begin
            if (i > 0) idle_n($urandom_range(0, 5));
            send(8'(i));
        end
        chk("t2_hv_after_last", header_valid, 1);
        chk_w("t2_header", block_header, e1);
        idle_n(3);
        chk("t2_hv_count", n_hv - hv0, 1);

        // Partial frame, flush, full frame
        do_reset();
        hv0 = n_hv;
        for (int i = 0; i < 40; i++) send(8'hAA);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < HB - 1; i++) send(8'h11);
        chk("t3_no_early_hv", n_hv - hv0, 0);
        send(8'h11);
        chk_w("t3_header", block_header, {HB{8'h11}});
        chk("t3_count", byte_count, 120);
        chk("t3_hv", header_valid, 1);

        for (int i = 0; i < HB; i++) begin
            rb[i] = 8'($urandom);
            e2[W-1-8*i -: 8] = rb[i];
        end
`ifdef HDR_TIMEOUT_EN
        do_reset();
        to0 = n_to;
        for (int i = 0; i < 10; i++) send(8'(i + 1));
        idle_n(TO - 1);
        chk("t4_no_early_to", n_to - to0, 0);
        chk("t4_busy_before", busy, 1);
        idle_n(1);
        chk("t4_timeout", timeout, 1);
        chk("t4_busy_after", busy, 0);
        idle_n(1);
        chk("t4_timeout_pulse", timeout, 0);
        chk("t4_to_count", n_to - to0, 1);
        for (int i = 0; i < HB; i++) send(rb[i]);
        chk_w("t4_header", block_header, e2);
        to0 = n_to;
        hv0 = n_hv;
        for (int i = 0; i < 10; i++) send(8'hC0);
        idle_n(TO - 1);
        send(8'hC1);
        chk("t4_no_timeout", n_to - to0, 0);
        for (int i = 0; i < HB - 12; i++) send(8'hC2);
        chk("t4_no_hv_yet", n_hv - hv0, 0);
        send(8'hC3);
        chk("t4_hv_at_80", header_valid, 1);
`else
        do_reset();
        to0 = n_to;
        for (int i = 0; i < 10; i++) send(rb[i]);
        idle_n(40);
        chk("t4_held_busy", busy, 1);
        chk("t4_no_timeout", n_to - to0, 0);
        for (int i = 10; i < HB; i++) send(rb[i]);
        chk("t4_hv", header_valid, 1);
        chk_w("t4_header", block_header, e2);
`endif

        // Two contiguous frames
        do_reset();
        hv_cyc.delete();
        for (int i = 0; i < HB; i++) e1[W-1-8*i -: 8] = 8'(i) ^ 8'h5C;
        for (int i = 0; i < HB; i++) e2[W-1-8*i -: 8] = 8'(i + HB) ^ 8'h5C;
        for (int i = 0; i < 2 * HB; i++) begin
            send(8'(i) ^ 8'h5C);
            if (i == 120 || i == 2 * HB - 2) chk_w("t5_hold_frame1", block_header, e1);
        end
        chk_w("t5_frame2", block_header, e2);
        chk("t5_pulses", hv_cyc.size(), 2);
        if (hv_cyc.size() == 2) chk("t5_spacing", hv_cyc[1] - hv_cyc[0], 80);

        // Reset coinciding with the 80th byte
        do_reset();
        for (int i = 0; i < HB; i++) send(8'hE0);
        for (int i = 0; i < HB - 1; i++) send(8'hE1);
        hv0 = n_hv;
        cycle(1'b1, 8'hEE, 1'b0, 1'b1);
        chk_w("t6_header", block_header, '0);
        chk("t6_hv", header_valid, 0);
        chk("t6_loaded", header_loaded, 0);
        chk("t6_busy", busy, 0);
        chk("t6_count", byte_count, 0);
        chk("t6_timeout", timeout, 0);
        idle_n(1);
        chk("t6_no_pulse", n_hv - hv0, 0);

        // Random traffic against the model
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 199) == 0) idle_n($urandom_range(10, 25));
            cycle($urandom_range(0, 9) < 7, 8'($urandom),
                  $urandom_range(0, 99) < 2, $urandom_range(0, 999) < 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
